alu_mdu: RTL
============

# alu_mdu

Parametrised successor to the pipeline's single-cycle execute ALU. It performs the RV32I integer operations with correct signed semantics for SRA and SLT. It adds the RV32M multiply/divide/remainder operations, which run on an iterative datapath. A valid/ready handshake on both sides lets the execute stage stall while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, operand and result width in bits; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), number of low bits of data_in_2 used as the shift amount.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; highest priority after reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- alu_op  input  5  operation code (see Operation).
- data_in_1  input  WIDTH  operand rs1.
- data_in_2  input  WIDTH  operand rs2 or immediate.
- out_valid  output  1  data_out holds a result.
- out_ready  input  1  consumer takes the result.
- data_out  output  WIDTH  result.
- busy  output  1  a multi-cycle operation is in flight.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SLL, 6 SRL, 7 SRA (arithmetic).
  - 8 SLT (signed), 9 SLTU.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Codes 18–31 produce result 0 with single-cycle latency.
- The shift amount is data_in_2[SHAMT_W-1:0]; upper bits are ignored.
- Request acceptance: a request is accepted on a rising edge when in_valid && in_ready. Operands and op are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- States:
  - IDLE:
    - A single-cycle op, or a divide special case, loads data_out, sets out_valid, and stays in IDLE.
    - An op in 10–13 goes to MUL.
    - Any other op in 14–17 goes to DIV.
  - MUL:
    - Shift-add on operand magnitudes, one partial product per cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
    - After the last iteration, the sign of the product is fixed up and then the slice is selected: low half for MUL, high half otherwise.
    - Then go to DONE.
  - DIV:
    - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
    - Signed ops negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
    - Then go to DONE.
  - DONE: load data_out, set out_valid, return to IDLE.
- Divide special cases (resolved at acceptance, single-cycle, no DIV state):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV gives the dividend; REM gives 0.
- Output hold: data_out and out_valid hold until out_ready is sampled high. out_valid falls on that edge unless a new single-cycle result loads on the same edge, in which case out_valid stays high with the new data.
- busy = (state==MUL || state==DIV || state==DONE).
- flush: returns to IDLE, clears out_valid, and discards any in-flight op. data_out keeps its value. A request presented in the same cycle as flush is not accepted.
- Reset (reset_n low, at any time including mid-operation):
  - State goes to IDLE.
  - out_valid = 0, data_out = 0, busy = 0, all internal accumulators 0.
  - in_ready = 1 from the first cycle after reset_n deasserts.

## Timing
- Single-cycle ops and divide special cases: accepted at edge N, out_valid is high after edge N. Latency 1.
- MUL*/DIV* (non-special): accepted at edge N, out_valid after edge N+WIDTH+1. Latency WIDTH+1 (33 at WIDTH=32).
- While busy, in_ready = 0. in_valid may be held high; the request is accepted on the first cycle in_ready returns.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- While out_valid && !out_ready, in_ready = 0 for all ops (no overwrite).
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.

## Test plan
- Signed ops: SRA 0x80000000 by 4 gives 0xF8000000; SLT(-1, 1) gives 1; SLTU(0xFFFFFFFF, 1) gives 0; SLL 1 by 0x21 gives 2 (shift amount masked).
- Multiply: MULH(-2, 3) gives 0xFFFFFFFF; MUL gives 0xFFFFFFFA. out_valid rises exactly 33 cycles after acceptance. MULHU(0xFFFFFFFF, 0xFFFFFFFF) gives 0xFFFFFFFE.
- Divide: DIV(-7, 2) gives 0xFFFFFFFD; REM(-7, 2) gives 0xFFFFFFFF. DIVU(x, 0) gives 0xFFFFFFFF at latency 1. DIV(0x80000000, -1) gives 0x80000000; REM gives 0.
- Backpressure: hold out_ready=0 after an ADD result, then present SUB. in_ready stays 0 and data_out is unchanged. Raise out_ready: SUB is accepted the same cycle and its result follows the next cycle.
- Abort: assert flush 10 cycles into a DIV; the next cycle shows IDLE, busy=0, out_valid=0. Separately, pull reset_n low mid-MUL: outputs are 0 immediately (asynchronous), and a fresh ADD(2, 3) after release gives 5.
- Parametrisation: at WIDTH=8, DIVU(200, 7) gives 28 with latency 9, and REMU gives 4.

Source files
------------

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// alu_mdu - RV32I ALU with iterative RV32M multiply/divide, valid/ready I/O
// Rev 1.0
// ============================================================================
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic [WIDTH-1:0] data_in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);
  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;
  localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] LAST    = SHAMT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [4:0]           op_r;
  logic                 neg_r;
  logic [SHAMT_W-1:0]   cnt;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res, mag_1, mag_2, div_sel, div_res, mul_res, fin_res;
  logic                 is_mul, is_div, is_special, sign_1, sign_2, neg_in, accept;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod;

  assign shamt      = data_in_2[SHAMT_W-1:0];
  assign is_mul     = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
  assign is_div     = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
  assign is_special = is_div && ((data_in_2 == '0) ||
                      ((alu_op == OP_DIV || alu_op == OP_REM) &&
                       data_in_1 == MIN_NEG && data_in_2 == '1));

  // Operand signs only count for the signed flavours of each op.
  assign sign_1 = data_in_1[WIDTH-1] && (alu_op == OP_MUL || alu_op == OP_MULH ||
                  alu_op == OP_MULHSU || alu_op == OP_DIV || alu_op == OP_REM);
  assign sign_2 = data_in_2[WIDTH-1] && (alu_op == OP_MUL || alu_op == OP_MULH ||
                  alu_op == OP_DIV || alu_op == OP_REM);
  assign mag_1  = sign_1 ? -data_in_1 : data_in_1;
  assign mag_2  = sign_2 ? -data_in_2 : data_in_2;
  assign neg_in = (alu_op == OP_REM) ? sign_1 : (sign_1 ^ sign_2);

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = data_in_1 + data_in_2;
      OP_SUB:  alu_res = data_in_1 - data_in_2;
      OP_XOR:  alu_res = data_in_1 ^ data_in_2;
      OP_OR:   alu_res = data_in_1 | data_in_2;
      OP_AND:  alu_res = data_in_1 & data_in_2;
      OP_SLL:  alu_res = data_in_1 << shamt;
      OP_SRL:  alu_res = data_in_1 >> shamt;
      OP_SRA:  alu_res = $signed(data_in_1) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data_in_1) < $signed(data_in_2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data_in_1 < data_in_2};
      OP_DIV, OP_DIVU: alu_res = (data_in_2 == '0) ? '1 : data_in_1;
      OP_REM, OP_REMU: alu_res = (data_in_2 == '0) ? data_in_1 : '0;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: upper half accumulates, multiplier drains from the bottom.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  // One restoring step: remainder in the upper half, dividend/quotient in the lower.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod    = neg_r ? -acc : acc;
  assign mul_res = (op_r == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign div_sel = (op_r == OP_DIV || op_r == OP_DIVU) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
  assign div_res = neg_r ? -div_sel : div_sel;
  assign fin_res = (op_r <= OP_MULHU) ? mul_res : div_res;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_r      <= '0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_r  <= alu_op;
          neg_r <= neg_in;
          cnt   <= '0;
          opnd  <= is_mul ? mag_1 : mag_2;
          acc   <= {{WIDTH{1'b0}}, is_mul ? mag_2 : mag_1};
          if (is_mul) begin
            state <= MUL;
          end else if (is_div && !is_special) begin
            state <= DIV;
          end else begin
            data_out  <= alu_res;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          data_out  <= fin_res;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
